accumulator_feeder: RTL and testbench

- Producer side of the accumulator's sample/increment interface.
- Buffers requested increment values in a small FIFO and issues each one as a single-cycle sample pulse with a held increment word. Consecutive pulses are spaced by a programmable gap.
- Keeps a shadow running total of everything issued, so the accumulator's Out can be checked against it.
- Sits between control/test logic and the accumulator instance.

---
 rtl/accumulator_feeder.sv | 143 ++++++++++++++
 tb/tb_accumulator_feeder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_feeder.sv
// Feeds queued increments to an accumulator as spaced single-cycle sample pulses
// and tracks a shadow running total. Optional acc_out comparator: FEEDER_CHECK_EN.
module accumulator_feeder #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             overflow,
    output logic             sample,
    output logic [WIDTH-1:0] increment,
    output logic             busy,
    output logic [WIDTH-1:0] expected,
    input  logic [WIDTH-1:0] acc_out,
    output logic             mismatch
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    state_t           state_reg;
    logic [GW-1:0]    gap_reg;
    logic             sample_reg;
    logic [WIDTH-1:0] increment_reg;
    logic [WIDTH-1:0] expected_reg;
    logic             overflow_reg;

    logic push_ok;
    logic gap_done;
    logic pop;

    // Acceptance and pop both look at the registered count, so a push into a
    // full FIFO is dropped even when a pop frees a slot in the same cycle.
    assign push_ok  = push && (count_reg != DEPTH_C);
    assign gap_done = (state_reg == S_WAIT) && (gap_reg == '0);
    assign pop      = (count_reg != '0) && ((state_reg == S_IDLE) || gap_done);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            state_reg     <= S_IDLE;
            gap_reg       <= '0;
            sample_reg    <= 1'b0;
            increment_reg <= '0;
            expected_reg  <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (push && !push_ok) begin
                overflow_reg <= 1'b1;
            end

            sample_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (pop) begin
                        increment_reg <= mem[rd_ptr_reg];
                        sample_reg    <= 1'b1;
                        state_reg     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    expected_reg <= expected_reg + increment_reg;
                    gap_reg      <= GAP_LOAD;
                    state_reg    <= S_WAIT;
                end
                S_WAIT: begin
                    if (gap_reg == '0) begin
                        if (pop) begin
                            increment_reg <= mem[rd_ptr_reg];
                            sample_reg    <= 1'b1;
                            state_reg     <= S_ISSUE;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end else begin
                        gap_reg <= gap_reg - 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign full      = (count_reg == DEPTH_C);
    assign overflow  = overflow_reg;
    assign sample    = sample_reg;
    assign increment = increment_reg;
    assign expected  = expected_reg;
    assign busy      = (state_reg != S_IDLE) || (count_reg != '0);

`ifdef FEEDER_CHECK_EN
    logic mismatch_reg;

    // The last gap cycle is the first point where acc_out reflects the pulse.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            mismatch_reg <= 1'b0;
        end else if (gap_done && (acc_out != expected_reg)) begin
            mismatch_reg <= 1'b1;
        end
    end

    assign mismatch = mismatch_reg;
`else
    logic acc_out_unused;

    assign acc_out_unused = ^acc_out;
    assign mismatch       = 1'b0;
`endif

endmodule

// File: tb/tb_accumulator_feeder.sv
// Self-checking bench for accumulator_feeder: vector table, scoreboard of issued
// increments, behavioural accumulator, and hand sequences for latency/reset/compare.
module tb_accumulator_feeder;

    localparam int WIDTH = 26;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;
`ifdef FEEDER_CHECK_EN
    localparam logic EXP_MM = 1'b1;
`else
    localparam logic EXP_MM = 1'b0;
`endif

    logic             clk;
    logic             GlobalReset;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             full;
    logic             overflow;
    logic             sample;
    logic [WIDTH-1:0] increment;
    logic             busy;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] acc_out;
    logic             mismatch;

    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] bias;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pulses  = 0;
    int last_pulse = -1;
    logic [WIDTH-1:0] sbq [$];

    accumulator_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk(clk), .GlobalReset(GlobalReset), .push(push), .push_data(push_data),
        .full(full), .overflow(overflow), .sample(sample), .increment(increment),
        .busy(busy), .expected(expected), .acc_out(acc_out), .mismatch(mismatch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural accumulator: adds increment at the edge ending a sample cycle.
    always @(posedge clk) begin
        if (GlobalReset) acc_reg <= '0;
        else if (sample) acc_reg <= acc_reg + increment;
    end
    assign acc_out = acc_reg + bias;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (GlobalReset) begin
            last_pulse = -1;
        end else if (sample) begin
            pulses++;
            if (sbq.size() == 0) begin
                check("sb_unexpected_pulse", 64'(increment), 64'hDEAD);
            end else begin
                check("sb_increment", 64'(increment), 64'(sbq.pop_front()));
            end
            if (last_pulse >= 0) check("pulse_spacing_ok", 64'(cyc - last_pulse >= GAP + 1), 64'd1);
            last_pulse = cyc;
        end
    end

    typedef struct {
        string               name;
        int                  n;
        logic [6:0][WIDTH-1:0] v;
        logic [6:0]          mask;
        logic [WIDTH-1:0]    sum;
        logic                ovf;
    } vec_t;

    function automatic vec_t mk(input string name, input int n, input logic [6:0] mask,
                                input logic [WIDTH-1:0] sum, input logic ovf,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d,
                                input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] f,
                                input logic [WIDTH-1:0] g);
        vec_t r;
        r.name = name; r.n = n; r.mask = mask; r.sum = sum; r.ovf = ovf;
        r.v = {g, f, e, d, c, b, a};
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        GlobalReset = 1'b1;
        push = 1'b0;
        sbq.delete();
        @(negedge clk);
        @(negedge clk);
        GlobalReset = 1'b0;
        pulses = 0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1;
                break;
            end
        end
        if (!done) check({name, "_idle_timeout"}, 64'd0, 64'd1);
    endtask

    vec_t vecs [5];

    initial begin
        int c0;
        int pc [$];
        logic full_seen;

        GlobalReset = 1'b1;
        push = 1'b0;
        push_data = '0;
        bias = '0;

        vecs[0] = mk("one",      1, 7'h01, 26'd1,   1'b0, 26'd1, 0, 0, 0, 0, 0, 0);
        vecs[1] = mk("two",      2, 7'h03, 26'd3,   1'b0, 26'd1, 26'd2, 0, 0, 0, 0, 0);
        vecs[2] = mk("overflow", 7, 7'h3F, 26'd210, 1'b1, 26'd10, 26'd20, 26'd30, 26'd40,
                     26'd50, 26'd60, 26'd70);
        vecs[3] = mk("wrap",     2, 7'h03, 26'd1,   1'b0, 26'h3FFFFFF, 26'd2, 0, 0, 0, 0, 0);
        vecs[4] = mk("three",    3, 7'h07, 26'd18,  1'b0, 26'd5, 26'd6, 26'd7, 0, 0, 0, 0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_sample", 64'(sample), 0);
        check("rst_increment", 64'(increment), 0);
        check("rst_expected", 64'(expected), 0);
        check("rst_full", 64'(full), 0);
        check("rst_overflow", 64'(overflow), 0);
        check("rst_mismatch", 64'(mismatch), 0);
        check("rst_busy", 64'(busy), 0);
        GlobalReset = 1'b0;

        // Latency: push in cycle N gives sample in N+2 only
        @(negedge clk);
        push = 1'b1; push_data = 26'd1; sbq.push_back(26'd1);
        @(negedge clk);
        push = 1'b0;
        check("lat_n1_sample", 64'(sample), 0);
        @(negedge clk);
        check("lat_n2_sample", 64'(sample), 1);
        check("lat_n2_increment", 64'(increment), 1);
        @(negedge clk);
        check("lat_n3_sample", 64'(sample), 0);
        check("lat_n3_expected", 64'(expected), 1);
        check("lat_n3_busy", 64'(busy), 1);
        @(negedge clk);
        check("lat_n4_busy", 64'(busy), 1);
        @(negedge clk);
        check("lat_n5_busy", 64'(busy), 0);
        check("lat_idle_increment_held", 64'(increment), 1);

        // Exact pulse spacing for two back-to-back pushes
        do_reset();
        @(negedge clk);
        c0 = cyc;
        push = 1'b1; push_data = 26'd1; sbq.push_back(26'd1);
        @(negedge clk);
        push_data = 26'd2; sbq.push_back(26'd2);
        @(negedge clk);
        push = 1'b0;
        pc.delete();
        for (int i = 0; i < 8; i++) begin
            if (sample) pc.push_back(cyc - c0);
            @(negedge clk);
        end
        check("spacing_npulses", 64'(pc.size()), 2);
        if (pc.size() == 2) begin
            check("spacing_first", 64'(pc[0]), 2);
            check("spacing_second", 64'(pc[1]), 5);
        end
        check("spacing_acc", 64'(acc_out), 3);
        check("spacing_mismatch", 64'(mismatch), 0);

        // Table-driven vectors
        foreach (vecs[k]) begin
            do_reset();
            full_seen = 1'b0;
            for (int i = 0; i < vecs[k].n; i++) begin
                @(negedge clk);
                full_seen |= full;
                push = 1'b1;
                push_data = vecs[k].v[i];
                if (vecs[k].mask[i]) sbq.push_back(vecs[k].v[i]);
            end
            @(negedge clk);
            push = 1'b0;
            wait_idle(vecs[k].name);
            check({vecs[k].name, "_expected"}, 64'(expected), 64'(vecs[k].sum));
            check({vecs[k].name, "_acc"}, 64'(acc_out), 64'(vecs[k].sum));
            check({vecs[k].name, "_overflow"}, 64'(overflow), 64'(vecs[k].ovf));
            check({vecs[k].name, "_full_seen"}, 64'(full_seen), 64'(vecs[k].ovf));
            check({vecs[k].name, "_pulses"}, 64'(pulses), 64'($countones(vecs[k].mask)));
            check({vecs[k].name, "_sb_empty"}, 64'(sbq.size()), 0);
            check({vecs[k].name, "_mismatch"}, 64'(mismatch), 0);
        end

        // Reset during WAIT with two entries still queued
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            push = 1'b1; push_data = 26'(4 + i);
        end
        sbq.push_back(26'd4);
        @(negedge clk);
        push = 1'b0;
        check("midrst_in_wait", 64'({sample, busy}), 64'b01);
        GlobalReset = 1'b1;
        sbq.delete();
        @(negedge clk);
        check("midrst_sample", 64'(sample), 0);
        check("midrst_busy", 64'(busy), 0);
        check("midrst_full", 64'(full), 0);
        check("midrst_expected", 64'(expected), 0);
        @(negedge clk);
        GlobalReset = 1'b0;
        pulses = 0;
        repeat (12) @(negedge clk);
        check("midrst_no_pulses", 64'(pulses), 0);
        check("midrst_acc", 64'(acc_out), 0);

        // Comparator: acc_out off by one during the gap
        do_reset();
        bias = 26'd1;
        @(negedge clk);
        push = 1'b1; push_data = 26'd7; sbq.push_back(26'd7);
        @(negedge clk);
        push = 1'b0;
        repeat (3) @(negedge clk);
        check("mm_before_last_wait", 64'(mismatch), 0);
        @(negedge clk);
        check("mm_after_last_wait", 64'(mismatch), 64'(EXP_MM));
        wait_idle("mm1");
        bias = '0;
        @(negedge clk);
        push = 1'b1; push_data = 26'd1; sbq.push_back(26'd1);
        @(negedge clk);
        push = 1'b0;
        wait_idle("mm2");
        check("mm_sticky", 64'(mismatch), 64'(EXP_MM));
        check("mm_expected", 64'(expected), 8);
        do_reset();
        check("mm_cleared", 64'(mismatch), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
